// File: rtl/sa_psum_collector.sv
// Deskews the staggered partial-sum lanes leaving the systolic array and queues
// complete rows in a first-word-fall-through FIFO toward the output buffer.
module sa_psum_collector #(
    parameter int PE_SIZE    = 2,
    parameter int PSUM_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_i,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0]    psum_row_i,
    input  logic [PE_SIZE-1:0]               psum_en_row_i,
    output logic [PSUM_WIDTH*PE_SIZE-1:0]    out_row_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic [15:0]                      rows_o,
    output logic                             misalign_err_o,
    output logic                             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = PSUM_WIDTH * PE_SIZE;

    logic          flush;
    logic [PE_SIZE-1:0] en_al;
    logic [RW-1:0] row_al;

    assign flush = rst || clear_i;

    // Lane i waits PE_SIZE-1-i cycles so every lane meets lane PE_SIZE-1.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        localparam int S = PE_SIZE - 1 - i;
        if (S == 0) begin : g_pass
            assign en_al[i] = psum_en_row_i[i];
            assign row_al[PSUM_WIDTH*i +: PSUM_WIDTH] = psum_row_i[PSUM_WIDTH*i +: PSUM_WIDTH];
        end else begin : g_chain
            logic [S-1:0]          en_q;
            logic [PSUM_WIDTH-1:0] dat_q [S];

            always_ff @(posedge clk) begin
                if (flush) begin
                    en_q <= '0;
                    for (int k = 0; k < S; k++) dat_q[k] <= '0;
                end else begin
                    en_q[0] <= psum_en_row_i[i];
                    if (psum_en_row_i[i]) dat_q[0] <= psum_row_i[PSUM_WIDTH*i +: PSUM_WIDTH];
                    for (int k = 1; k < S; k++) begin
                        en_q[k] <= en_q[k-1];
                        if (en_q[k-1]) dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign en_al[i] = en_q[S-1];
            assign row_al[PSUM_WIDTH*i +: PSUM_WIDTH] = dat_q[S-1];
        end
    end

    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   rows_q, rows_d;
    logic          misalign_q, misalign_d;
    logic          overflow_q, overflow_d;
    logic          row_full, row_part, pop, push;

    assign row_full = &en_al;
    assign row_part = (|en_al) && !row_full;
    assign pop      = (count_q != '0) && out_ready_i;
    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign push     = row_full && ((count_q != CW'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rows_d     = rows_q;
        misalign_d = misalign_q || row_part;
        overflow_d = overflow_q || (row_full && !push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rows_d   = rows_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rows_q     <= '0;
            misalign_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rows_q     <= rows_d;
            misalign_q <= misalign_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && push) mem_q[wr_ptr_q] <= row_al;
    end

    assign out_valid_o    = (count_q != '0);
    assign out_row_o      = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o        = count_q;
    assign rows_o         = rows_q;
    assign misalign_err_o = misalign_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sa_psum_collector.sv
// Directed and randomized checks of sa_psum_collector against a row-level
// reference model built from per-cycle input history and a queue of rows.
module tb_sa_psum_collector;

    localparam int P    = 2;
    localparam int W    = 32;
    localparam int D    = 4;
    localparam int RW   = P * W;
    localparam int CW   = $clog2(D) + 1;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst, clear_i, out_ready_i;
    logic [RW-1:0] psum_row_i, out_row_o;
    logic [P-1:0]  psum_en_row_i;
    logic          out_valid_o;
    logic [CW-1:0] count_o;
    logic [15:0]   rows_o;
    logic          misalign_err_o, overflow_o;

    always #5 clk = ~clk;

    sa_psum_collector #(.PE_SIZE(P), .PSUM_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .psum_row_i(psum_row_i), .psum_en_row_i(psum_en_row_i),
        .out_row_o(out_row_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .count_o(count_o), .rows_o(rows_o),
        .misalign_err_o(misalign_err_o), .overflow_o(overflow_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_clr = -1;

    logic [P-1:0] plan_en  [MAXC];
    logic [W-1:0] plan_dat [MAXC][P];
    logic [P-1:0] hist_en  [MAXC];
    logic [W-1:0] hist_dat [MAXC][P];

    logic [RW-1:0] q[$];
    int            m_rows = 0;
    bit            m_mis = 1'b0;
    bit            m_ovf = 1'b0;
    logic          r_rst, r_clr, r_rdy;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_model();
        check("valid", RW'(out_valid_o), RW'(q.size() != 0));
        check("count", RW'(count_o), RW'(q.size()));
        check("rows", RW'(rows_o), RW'(16'(m_rows)));
        check("misalign", RW'(misalign_err_o), RW'(m_mis));
        check("overflow", RW'(overflow_o), RW'(m_ovf));
        if (q.size() != 0) check("head", out_row_o, q[0]);
    endtask

    function automatic void sched(int s, logic [RW-1:0] row, logic [P-1:0] mask);
        for (int i = 0; i < P; i++) begin
            plan_en[s+i][i]  = mask[i];
            plan_dat[s+i][i] = row[i*W +: W];
        end
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < P; i++) r[i*W +: W] = $urandom();
        return r;
    endfunction

    task automatic drive();
        rst           = r_rst;
        clear_i       = r_clr;
        out_ready_i   = r_rdy;
        psum_en_row_i = plan_en[cyc];
        for (int i = 0; i < P; i++) begin
            psum_row_i[i*W +: W] = plan_en[cyc][i] ? plan_dat[cyc][i] : $urandom();
            hist_dat[cyc][i]     = psum_row_i[i*W +: W];
        end
        hist_en[cyc] = plan_en[cyc];
    endtask

    // Lane i of the row judged in cycle c is whatever lane i carried in cycle
    // c-(P-1-i), provided that cycle came after the most recent reset/clear.
    task automatic model_step();
        logic [P-1:0]  al;
        logic [RW-1:0] row;
        bit            pop;
        bit            push;
        int            src;
        al   = '0;
        row  = '0;
        push = 1'b0;
        if (r_rst || r_clr) begin
            q.delete();
            m_rows   = 0;
            m_mis    = 1'b0;
            m_ovf    = 1'b0;
            last_clr = cyc;
            return;
        end
        for (int i = 0; i < P; i++) begin
            src = cyc - (P - 1 - i);
            if (src > last_clr) begin
                al[i]          = hist_en[src][i];
                row[i*W +: W]  = hist_dat[src][i];
            end
        end
        pop = (q.size() != 0) && r_rdy;
        if (al == '1) begin
            if (q.size() < D || pop) push = 1'b1;
            else m_ovf = 1'b1;
        end else if (al != '0) begin
            m_mis = 1'b1;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(row);
            m_rows = (m_rows + 1) % 65536;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        drive();
        #1;
        if (cyc > 0) check_model();
        model_step();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) run_cycle();
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        r_clr = 1'b1;
        run(1);
        r_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] rr [5];
        logic [P-1:0]  mask;
        bit            free;
        int            s;

        for (int c = 0; c < MAXC; c++) begin
            plan_en[c] = '0;
            for (int i = 0; i < P; i++) plan_dat[c][i] = '0;
        end
        r_rst = 1'b1; r_clr = 1'b0; r_rdy = 1'b0;
        run(2);
        r_rst = 1'b0;
        settle();
        check("rst_row", out_row_o, '0);
        check("rst_valid", RW'(out_valid_o), '0);
        check("rst_count", RW'(count_o), '0);
        check("rst_rows", RW'(rows_o), '0);

        // Single row: lane0 0x10 then lane1 0x20, visible two cycles after lane0.
        r_rdy = 1'b1;
        sched(cyc, 64'h00000020_00000010, 2'b11);
        run(2);
        settle();
        check("single_row", out_row_o, 64'h00000020_00000010);
        check("single_valid", RW'(out_valid_o), RW'(1));
        check("single_rows", RW'(rows_o), RW'(1));
        check("single_flags", RW'({misalign_err_o, overflow_o}), '0);
        run(3);

        // Streaming three back-to-back rows with ready held high.
        for (int k = 0; k < 3; k++) begin
            rr[k] = rand_row();
            sched(cyc + k, rr[k], '1);
        end
        run(2);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stream_row", out_row_o, rr[k]);
            check("stream_valid", RW'(out_valid_o), RW'(1));
            check("stream_count", RW'(count_o), RW'(1));
            run(1);
        end
        settle();
        check("stream_done", RW'(out_valid_o), '0);
        run(2);

        // Backpressure: five rows into a four-deep FIFO.
        do_clear();
        r_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rr[k] = rand_row();
            sched(cyc + k, rr[k], '1);
        end
        run(7);
        settle();
        check("ovf_count", RW'(count_o), RW'(4));
        check("ovf_flag", RW'(overflow_o), RW'(1));
        check("ovf_rows", RW'(rows_o), RW'(4));
        check("ovf_head", out_row_o, rr[0]);
        r_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_row", out_row_o, rr[k]);
            run(1);
            settle();
        end
        check("drain_empty", RW'(out_valid_o), '0);

        // Full FIFO accepts a row when a pop happens in the same cycle.
        do_clear();
        r_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rr[k] = rand_row();
            sched(cyc + k, rr[k], '1);
        end
        run(6);
        settle();
        check("full_count", RW'(count_o), RW'(4));
        rr[4] = rand_row();
        sched(cyc, rr[4], '1);
        run(1);
        r_rdy = 1'b1;
        run(1);
        r_rdy = 1'b0;
        settle();
        check("fullpop_count", RW'(count_o), RW'(4));
        check("fullpop_ovf", RW'(overflow_o), '0);
        check("fullpop_rows", RW'(rows_o), RW'(5));
        check("fullpop_head", out_row_o, rr[1]);
        r_rdy = 1'b1;
        run(8);

        // Misaligned row: lane0 only.
        do_clear();
        s = cyc;
        sched(cyc, rand_row(), 2'b01);
        run(2);
        settle();
        check("mis_flag", RW'(misalign_err_o), RW'(1));
        check("mis_rows", RW'(rows_o), '0);
        check("mis_count", RW'(count_o), '0);
        run(2);

        // Clear with two rows buffered, one in flight and flags set.
        do_clear();
        r_rdy = 1'b0;
        sched(cyc, rand_row(), 2'b01);
        sched(cyc + 1, rand_row(), '1);
        sched(cyc + 2, rand_row(), '1);
        run(5);
        settle();
        check("pre_clear_count", RW'(count_o), RW'(2));
        sched(cyc, rand_row(), '1);
        run(1);
        r_clr = 1'b1;
        run(1);
        r_clr = 1'b0;
        settle();
        check("clr_count", RW'(count_o), '0);
        check("clr_valid", RW'(out_valid_o), '0);
        check("clr_flags", RW'({misalign_err_o, overflow_o}), '0);
        check("clr_rows", RW'(rows_o), '0);
        r_rdy = 1'b1;
        run(4);

        // Randomized traffic: light then heavy backpressure, occasional clears.
        for (int n = 0; n < 300; n++) begin
            r_rdy = (n < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            r_clr = ($urandom_range(0, 99) == 0);
            free = 1'b1;
            for (int i = 0; i < P; i++) if (plan_en[cyc+i][i]) free = 1'b0;
            if (free && $urandom_range(0, 2) != 0) begin
                mask = ($urandom_range(0, 14) == 0) ? P'($urandom()) : '1;
                sched(cyc, rand_row(), mask);
            end
            run(1);
        end
        r_clr = 1'b0;
        r_rdy = 1'b1;
        run(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
